square_iter: RTL and testbench
==============================

# square_iter

Sequential shift-and-add squarer that inverts the integer square root: it takes an 11-bit root `r` and returns the 21-bit square `r*r`. Results that do not fit in 21 bits saturate and raise an overflow flag. It sits beside the square-root unit in the arithmetic path. It is used wherever a root must be re-expanded, for example to check `sqrt(x)` or to compute a residual `x - r*r`. Operands and results move over valid/ready handshakes, and the block processes one operation at a time.

## Interface
- `RW`, default 11: root width, in bits.
- `SW`, default 21: square/result width, in bits.
- `clk` input, 1 bit: the single clock; all state updates on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `in_valid` input, 1 bit: `r` is valid.
- `in_ready` output, 1 bit: the block can accept an operand.
- `r` input, `RW` bits: unsigned root operand.
- `out_valid` output, 1 bit: `y` and `ovf` are valid.
- `out_ready` input, 1 bit: the downstream block accepts the result.
- `y` output, `SW` bits: `r*r`, saturated to `2^SW-1`.
- `ovf` output, 1 bit: set when `r*r > 2^SW-1`.

## Operation
- State machine with three states: IDLE, CALC, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: latch `r` into the operand register, clear the 22-bit accumulator `acc`, set `cnt`=0, go to CALC.
- CALC (`in_ready`=0):
  - Each cycle: if `op[cnt]`=1, then `acc <= acc + (op << cnt)`. Then `cnt <= cnt+1`.
  - When the bit with `cnt`=`RW-1` has been processed, go to DONE.
  - Exactly `RW` CALC cycles; there is no early exit on zero bits.
- Arithmetic:
  - `acc` is `SW+1` = 22 bits wide. The maximum is 2047² = 4190209 < 2²², so `acc` never wraps.
  - `ovf = acc[SW]`.
  - `y = ovf ? {SW{1'b1}} : acc[SW-1:0]`.
  - The largest non-saturating root is 1448 (1448² = 2096704). Roots 1449–2047 saturate.
- DONE:
  - `out_valid`=1; `y`/`ovf` are driven from registers and stay stable.
  - On `out_ready` high: go to IDLE and drop `out_valid` in the next cycle.
  - While `out_ready` is low: hold the state and the outputs indefinitely.
- `in_valid` is ignored outside IDLE; the operand is not queued.
- `r` is sampled only at the accept edge. Later changes to `r` do not affect the result in progress.
- Round-trip property: for `x` < 2²¹, `r = sqrt(x)` satisfies `r*r <= x` and `ovf`=0.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - State goes to IDLE; `cnt`, `op`, `acc` clear to 0.
  - Outputs: `in_ready`=1, `out_valid`=0, `y`=0, `ovf`=0.
  - Release of reset is synchronous to `clk`.
- Reset mid-CALC or mid-DONE: the operation is aborted and no result is emitted. After release, the block is in IDLE and ready.
- Latency: operand accepted at edge E0 means `out_valid`=1 in the cycle following edge E0+`RW` (11 cycles).
- Throughput: at best one result per `RW`+2 cycles (accept, 11 CALC cycles, DONE). When `out_ready`=1 in the first DONE cycle, the next operand can be accepted no earlier than edge E0+`RW`+2.
- `in_ready` and `out_valid` are never high in the same cycle.
- `out_valid`, `y`, `ovf` are registered outputs with no combinational path from any input.
- `in_ready` depends only on the state, not combinationally on `out_ready`.

## Test plan
- Reset, then `r`=0 accepted → after 11 cycles `out_valid`=1, `y`=0, `ovf`=0; with `out_ready`=1, the block is in IDLE one cycle later.
- `r`=1448, `r`=37, `r`=1024 in sequence, with `out_ready` tied high → `y` = 2096704 / 1369 / 1048576, `ovf`=0 for all. Each result appears exactly 11 cycles after its accept edge.
- `r`=1449 → `y`=2097151, `ovf`=1. `r`=2047 → `y`=2097151, `ovf`=1.
- Backpressure:
  - `r`=5, with `out_ready` held low for 20 cycles → `out_valid` stays 1 and `y`=25 stays stable, with `in_ready`=0 throughout.
  - Pulsing `in_valid` with `r`=9 during that window → no effect.
  - Raising `out_ready` → one handshake, then back to IDLE.
- Reset mid-operation: accept `r`=100, assert `rst_n`=0 at CALC cycle 5 → outputs immediately at reset values. After release, `r`=3 → `y`=9, and no stale result is seen.
- Exhaustive round-trip against the square-root unit, all `r` 0..2047 → `y` equals min(`r`², 2097151) and `ovf` equals (`r`>1448).
  - For `r`≤1448: `sqrt(y)`=`r`.
  - Handshake ordering holds for every operation.

Source files
------------

// File: rtl/square_iter_if.sv
// Handshake bundle for square_iter.
//   master: issues roots (in_valid, r) and accepts results (out_ready).
//   slave : the squarer; returns in_ready, out_valid, y, ovf.
interface square_iter_if #(
  parameter int unsigned RW = 11,
  parameter int unsigned SW = 21
);
  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] r;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] y;
  logic          ovf;

  modport master (
    output in_valid, r, out_ready,
    input  in_ready, out_valid, y, ovf
  );

  modport slave (
    input  in_valid, r, out_ready,
    output in_ready, out_valid, y, ovf
  );
endinterface

// File: rtl/square_iter.sv
// Sequential shift-and-add squarer: y = r*r, saturated to 2^SW-1 with ovf raised.
// One operation at a time: IDLE accepts a root, CALC runs exactly RW add/shift
// steps, DONE holds the registered result until the consumer takes it.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : square_iter_if.slave (in_valid/in_ready/r, out_valid/out_ready/y/ovf)
module square_iter #(
  parameter int unsigned RW = 11,
  parameter int unsigned SW = 21
) (
  input logic          clk,
  input logic          rst_n,
  square_iter_if.slave bus
);

  localparam int unsigned CW = $clog2(RW);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e        state;
  logic [RW-1:0] op;
  logic [CW-1:0] cnt;
  // One bit wider than the result so the largest square never wraps.
  logic [SW:0]   acc;
  logic [SW:0]   addend;
  logic [SW:0]   acc_nxt;
  logic          last;
  logic [SW-1:0] y_q;
  logic          ovf_q;
  logic          out_valid_q;

  assign addend  = {{(SW + 1 - RW){1'b0}}, op} << cnt;
  assign acc_nxt = op[cnt] ? acc + addend : acc;
  assign last    = (cnt == CW'(RW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= StIdle;
      op          <= '0;
      cnt         <= '0;
      acc         <= '0;
      y_q         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (bus.in_valid) begin
            op    <= bus.r;
            acc   <= '0;
            cnt   <= '0;
            state <= StCalc;
          end
        end
        StCalc: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (last) begin
            // Result registers load from the final partial sum on the same edge.
            state       <= StDone;
            out_valid_q <= 1'b1;
            ovf_q       <= acc_nxt[SW];
            y_q         <= acc_nxt[SW] ? {SW{1'b1}} : acc_nxt[SW-1:0];
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state == StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_square_iter.sv
module tb_square_iter;

  localparam int unsigned RW   = 11;
  localparam int unsigned SW   = 21;
  localparam int          YMAX = 2097151;

  typedef struct {
    int root;
    int ey;
    bit eovf;
    int acc_edge;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   last_acc = 0;
  int   this_acc = 0;
  bit   prev_hs = 1'b0;
  bit   prev_ov = 1'b0;
  exp_t sbq[$];

  square_iter_if #(.RW(RW), .SW(SW)) bus ();

  square_iter #(.RW(RW), .SW(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int isqrt(input int v);
    int res;
    int t;
    res = 0;
    for (int b = 11; b >= 0; b--) begin
      t = res | (1 << b);
      if (t * t <= v) res = t;
    end
    return res;
  endfunction

  // Present one root; waits (bounded) for in_ready, optionally queues the expected result.
  task automatic send(input int val, input bit expect_res, input int ey, input bit eovf);
    int waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0 for root %0d", val);
      return;
    end
    bus.r        = RW'(val);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    last_acc     = this_acc;
    this_acc     = cyc;
    bus.in_valid = 1'b0;
    bus.r        = RW'($urandom);
    if (expect_res) begin
      e.root     = val;
      e.ey       = ey;
      e.eovf     = eovf;
      e.acc_edge = cyc;
      sbq.push_back(e);
    end
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (sbq.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (sbq.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results still pending", sbq.size());
      sbq.delete();
    end
  endtask

  // Monitor: latency on each new result, values on each handshake, ordering invariants.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_valid_exclusive", 64'(bus.in_ready & bus.out_valid), 64'd0);
      if (prev_hs) begin
        check("post_handshake_out_valid", 64'(bus.out_valid), 64'd0);
        check("post_handshake_in_ready", 64'(bus.in_ready), 64'd1);
      end
      if (bus.out_valid && !prev_ov) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: y=%0d ovf=%0d with nothing pending", bus.y, bus.ovf);
        end else begin
          check("latency", 64'(cyc - sbq[0].acc_edge), 64'd11);
        end
      end
      if (bus.out_valid && bus.out_ready && sbq.size() != 0) begin
        check($sformatf("y[r=%0d]", sbq[0].root), 64'(bus.y), 64'(sbq[0].ey));
        check($sformatf("ovf[r=%0d]", sbq[0].root), 64'(bus.ovf), 64'(sbq[0].eovf));
        if (!sbq[0].eovf)
          check($sformatf("sqrt_roundtrip[r=%0d]", sbq[0].root), 64'(isqrt(int'(bus.y))),
                64'(sbq[0].root));
        void'(sbq.pop_front());
      end
      prev_hs <= bus.out_valid && bus.out_ready;
      prev_ov <= bus.out_valid;
    end else begin
      prev_hs <= 1'b0;
      prev_ov <= 1'b0;
    end
  end

  initial begin
    int waited;
    bus.in_valid  = 1'b0;
    bus.r         = '0;
    bus.out_ready = 1'b1;
    #12;
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_y", 64'(bus.y), 64'd0);
    check("reset_ovf", 64'(bus.ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero root
    send(0, 1'b1, 0, 1'b0);
    drain();

    // Back-to-back with out_ready high: one accept every 13 cycles
    send(1448, 1'b1, 2096704, 1'b0);
    send(37, 1'b1, 1369, 1'b0);
    check("throughput_37", 64'(this_acc - last_acc), 64'd13);
    send(1024, 1'b1, 1048576, 1'b0);
    check("throughput_1024", 64'(this_acc - last_acc), 64'd13);
    drain();

    // Saturation
    send(1449, 1'b1, 2097151, 1'b1);
    send(2047, 1'b1, 2097151, 1'b1);
    drain();

    // Backpressure with ignored in_valid pulses
    bus.out_ready = 1'b0;
    send(5, 1'b1, 25, 1'b0);
    waited = 0;
    while (!bus.out_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    for (int i = 0; i < 20; i++) begin
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_y", 64'(bus.y), 64'd25);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      bus.in_valid = (i % 4 == 1);
      bus.r        = 11'd9;
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    repeat (20) @(negedge clk);

    // Reset during CALC aborts the operation
    send(100, 1'b0, 0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_in_ready", 64'(bus.in_ready), 64'd1);
    check("midreset_out_valid", 64'(bus.out_valid), 64'd0);
    check("midreset_y", 64'(bus.y), 64'd0);
    check("midreset_ovf", 64'(bus.ovf), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(3, 1'b1, 9, 1'b0);
    drain();
    repeat (20) @(negedge clk);

    // Every root
    for (int i = 0; i < 2048; i++) begin
      send(i, 1'b1, (i * i > YMAX) ? YMAX : i * i, i > 1448);
    end
    drain();
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
